// File: rtl/ddr_model.sv
// Single-port word memory standing in for external DDR: writes commit on the
// sampling edge, reads return through a fixed-latency pipeline with a one-cycle valid.
module ddr_model #(
    parameter  int unsigned DATA_WIDTH   = 32,
    parameter  int unsigned DEPTH        = 1024,
    parameter  int unsigned READ_LATENCY = 4,
    localparam int unsigned ADDR_WIDTH   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_req,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    // Contents power up cleared and deliberately survive reset.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [DATA_WIDTH-1:0]   pipe_dat_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   pipe_dat_d [READ_LATENCY];
    logic                    rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

    logic                    rd_fire;
    logic                    wr_fire;
    logic                    in_range;
    logic [DATA_WIDTH-1:0]   rd_word;

    always_comb begin
        in_range = ({1'b0, addr} < DEPTH_LIM);
        // if-form keeps unknown request levels from launching anything
        rd_fire  = 1'b0;
        wr_fire  = 1'b0;
        if (!reset) begin
            if (rd_req) rd_fire = 1'b1;
            if (wr_req) wr_fire = 1'b1;
        end

        rd_word = '0;
        if (in_range) rd_word = mem_q[addr];

        pipe_vld_d    = '0;
        pipe_dat_d    = '{default: '0};
        pipe_vld_d[0] = rd_fire;
        pipe_dat_d[0] = rd_word;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_dat_d[i] = pipe_dat_q[i-1];
        end

        rd_valid_d = pipe_vld_q[READ_LATENCY-1];
        rd_data_d  = rd_data_q;
        if (pipe_vld_q[READ_LATENCY-1]) rd_data_d = pipe_dat_q[READ_LATENCY-1];
    end

    // Read captures the pre-write word, giving read-before-write on address collision.
    always_ff @(posedge clk) begin
        if (wr_fire && in_range) mem_q[addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        pipe_dat_q <= pipe_dat_d;
        if (reset) begin
            pipe_vld_q <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ddr_model.sv
// Directed bench for ddr_model: one vector table driven into three instances
// with read latencies 4, 1 and 8, plus hand-written multi-cycle sequences.
module tb_ddr_model;

    localparam int NV = 30;

    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;   // word a read issued by this vector must return
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, rd_req, wr_req;
    logic [9:0]  addr;
    logic [31:0] wr_data;
    logic        rv  [3];
    logic [31:0] rdv [3];

    int          lats [3] = '{4, 1, 8};
    logic [31:0] exp_data [3];
    vec_t        vecs [NV];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ddr_model #(.READ_LATENCY(4)) u_lat4 (
        .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
        .wr_data(wr_data), .rd_data(rdv[0]), .rd_valid(rv[0]));
    ddr_model #(.READ_LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
        .wr_data(wr_data), .rd_data(rdv[1]), .rd_valid(rv[1]));
    ddr_model #(.READ_LATENCY(8)) u_lat8 (
        .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
        .wr_data(wr_data), .rd_data(rdv[2]), .rd_valid(rv[2]));

    task automatic check(input string name, input int lat, input int step,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lat=%0d step=%0d got=%h expected=%h", name, lat, step, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rd, input logic wr,
                         input logic [9:0] a, input logic [31:0] d);
        reset = r; rd_req = rd; wr_req = wr; addr = a; wr_data = d;
    endtask

    initial begin
        int m;
        logic ev;
        int cnt [3];
        int seen [3];

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 10'd0,  32'h0,        32'h0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 10'd10, 32'h99999999, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 10'd10, 32'hDEADBEEF, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 10'd10, 32'h0,        32'hDEADBEEF};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 10'd5,  32'h0,        32'h0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 10'd0,  32'h11111111, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 10'd1,  32'h22222222, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 10'd2,  32'h33333333, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 10'd3,  32'h44444444, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 10'd0,  32'h0,        32'h11111111};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 10'd1,  32'h0,        32'h22222222};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 10'd2,  32'h0,        32'h33333333};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 10'd3,  32'h0,        32'h44444444};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 10'd10, 32'hCAFEF00D, 32'hDEADBEEF};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 10'd10, 32'h0,        32'hCAFEF00D};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 10'd10, 32'h0,        32'hCAFEF00D};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 10'd10, 32'h0,        32'h0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 10'd10, 32'h0,        32'hCAFEF00D};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 10'd10, 32'h12345678, 32'h0};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 10'd10, 32'h0,        32'h12345678};
        for (int i = 20; i < NV; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, 10'd0, 32'h0, 32'h0};

        drive(1'b1, 1'b0, 1'b0, 10'd0, 32'h0);
        for (int li = 0; li < 3; li++) exp_data[li] = 32'h0;

        // Table: a read from vector m shows up after edge m+L unless a reset edge intervenes.
        for (int n = 0; n < NV; n++) begin
            drive(vecs[n].rst, vecs[n].rd, vecs[n].wr, vecs[n].addr, vecs[n].wdata);
            @(posedge clk);
            #1;
            for (int li = 0; li < 3; li++) begin
                m  = n - lats[li];
                ev = 1'b0;
                if (vecs[n].rst) begin
                    exp_data[li] = 32'h0;
                end else if (m >= 0 && vecs[m].rd && !vecs[m].rst) begin
                    ev = 1'b1;
                    for (int k = m + 1; k <= n; k++) if (vecs[k].rst) ev = 1'b0;
                end
                if (ev) exp_data[li] = vecs[m].exp_rdata;
                check("vec_rd_valid", lats[li], n, {31'h0, rv[li]}, {31'h0, ev});
                check("vec_rd_data",  lats[li], n, rdv[li], exp_data[li]);
            end
        end

        // Held rd_req for three edges yields three reads.
        for (int li = 0; li < 3; li++) cnt[li] = 0;
        drive(1'b0, 1'b1, 1'b0, 10'd2, 32'h0);
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) drive(1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
            for (int li = 0; li < 3; li++) begin
                if (rv[li]) begin
                    cnt[li]++;
                    check("held_rd_data", lats[li], c, rdv[li], 32'h33333333);
                end
            end
        end
        for (int li = 0; li < 3; li++) check("held_rd_count", lats[li], 0, cnt[li], 3);

        // Held wr_req for two edges: second write wins; then time the read return.
        drive(1'b0, 1'b0, 1'b1, 10'd20, 32'hAAAA5555);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b1, 10'd20, 32'hBBBB6666);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 1'b0, 10'd20, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
        for (int li = 0; li < 3; li++) seen[li] = 0;
        for (int c = 1; c <= 12; c++) begin
            for (int li = 0; li < 3; li++) begin
                if (rv[li] && seen[li] == 0) begin
                    seen[li] = c - 1;
                    check("held_wr_data", lats[li], c, rdv[li], 32'hBBBB6666);
                end
            end
            @(posedge clk);
            #1;
        end
        for (int li = 0; li < 3; li++) check("read_latency", lats[li], 0, seen[li], lats[li]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
